// File: rtl/enemy_missile_pool_if.sv
// Formation-side inputs and missile-side outputs of enemy_missile_pool.
// player_X exists only when ENEMY_MISSILE_AIM_EN is defined.
interface enemy_missile_pool_if #(
  parameter int NUM_ENEMY   = 24,
  parameter int NUM_MISSILE = 4
) ();
  logic                         freeze;
  logic [NUM_ENEMY-1:0][9:0]    enemy_posX;
  logic [NUM_ENEMY-1:0][9:0]    enemy_posY;
  logic [NUM_ENEMY-1:0]         present;
  logic [NUM_MISSILE-1:0]       hit_clr;
`ifdef ENEMY_MISSILE_AIM_EN
  logic [9:0]                   player_X;
`endif
  logic [NUM_MISSILE-1:0][9:0]  beam_X;
  logic [NUM_MISSILE-1:0][9:0]  beam_Y;
  logic [NUM_MISSILE-1:0]       beam_enable;
  logic                         fire_pulse;

  modport master (
    output freeze, enemy_posX, enemy_posY, present, hit_clr,
`ifdef ENEMY_MISSILE_AIM_EN
    output player_X,
`endif
    input  beam_X, beam_Y, beam_enable, fire_pulse
  );

  modport slave (
    input  freeze, enemy_posX, enemy_posY, present, hit_clr,
`ifdef ENEMY_MISSILE_AIM_EN
    input  player_X,
`endif
    output beam_X, beam_Y, beam_enable, fire_pulse
  );
endinterface

// File: rtl/enemy_missile_pool.sv
// Enemy fire generator: NUM_MISSILE independent falling missiles, LFSR-picked shooter, launch cooldown.
// Optional ENEMY_MISSILE_AIM_EN: flying missiles also drift 1 px/frame toward player_X.
//
// Slot state | meaning
// S_IDLE     | slot free, beam_X/Y held at 0, not drawn
// S_FLY      | missile falling STEP_Y px per unfrozen frame
module enemy_missile_pool #(
  parameter int NUM_ENEMY   = 24,
  parameter int NUM_MISSILE = 4,
  parameter int STEP_Y      = 4,
  parameter int Y_LIMIT     = 287,
  parameter int SPAWN_DY    = 8,
  parameter int COOLDOWN    = 8
) (
  input logic                frame_clk,
  input logic                Reset,
  enemy_missile_pool_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_ENEMY);
  localparam int IDX_W1 = IDX_W + 1;
  localparam int CD_W   = $clog2(COOLDOWN + 1);

  localparam logic [9:0]      STEP_V    = 10'(STEP_Y);
  localparam logic [9:0]      SPAWN_V   = 10'(SPAWN_DY);
  localparam logic [9:0]      RETIRE_Y  = 10'(Y_LIMIT - STEP_Y);
  localparam logic [IDX_W:0]  ENEMY_CNT = IDX_W1'(NUM_ENEMY);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE    = CD_W'(1);

  typedef enum logic {S_IDLE = 1'b0, S_FLY = 1'b1} slot_state_t;

  slot_state_t st_q [NUM_MISSILE];
  slot_state_t st_d [NUM_MISSILE];
  logic [9:0]  x_q  [NUM_MISSILE];
  logic [9:0]  x_d  [NUM_MISSILE];
  logic [9:0]  y_q  [NUM_MISSILE];
  logic [9:0]  y_d  [NUM_MISSILE];

  logic [7:0]      lfsr_q, lfsr_d;
  logic [CD_W-1:0] cd_q, cd_d;
  logic            fire_q, fire_d;

  logic [IDX_W-1:0]       cand;
  logic                   cand_ok;
  logic [9:0]             spawn_x, spawn_y;
  logic [NUM_MISSILE-1:0] free_sel;
  logic                   free_any;
  logic                   launch;

  assign cand    = lfsr_q[IDX_W-1:0];
  assign cand_ok = ({1'b0, cand} < ENEMY_CNT) && bus.present[cand];
  assign spawn_x = bus.enemy_posX[cand];
  assign spawn_y = bus.enemy_posY[cand] + SPAWN_V;

  // A slot being cleared this frame is still busy for allocation purposes.
  always_comb begin
    free_sel = '0;
    free_any = 1'b0;
    for (int i = 0; i < NUM_MISSILE; i++) begin
      if (!free_any && st_q[i] == S_IDLE && !bus.hit_clr[i]) begin
        free_sel[i] = 1'b1;
        free_any    = 1'b1;
      end
    end
  end

  assign launch = !bus.freeze && (cd_q == '0) && cand_ok && free_any;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    fire_d = launch;
    cd_d   = cd_q;
    if (launch)
      cd_d = CD_LOAD;
    else if (!bus.freeze && cd_q != '0)
      cd_d = cd_q - CD_ONE;

    for (int i = 0; i < NUM_MISSILE; i++) begin
      st_d[i] = st_q[i];
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      if (bus.hit_clr[i]) begin
        st_d[i] = S_IDLE;
        x_d[i]  = '0;
        y_d[i]  = '0;
      end else if (!bus.freeze) begin
        if (st_q[i] == S_FLY) begin
          // Retiring one step early keeps Y+STEP_Y from ever wrapping 10 bits.
          if (y_q[i] >= RETIRE_Y) begin
            st_d[i] = S_IDLE;
            x_d[i]  = '0;
            y_d[i]  = '0;
          end else begin
            y_d[i] = y_q[i] + STEP_V;
`ifdef ENEMY_MISSILE_AIM_EN
            if (x_q[i] < bus.player_X)
              x_d[i] = x_q[i] + 10'd1;
            else if (x_q[i] > bus.player_X)
              x_d[i] = x_q[i] - 10'd1;
`endif
          end
        end else if (launch && free_sel[i]) begin
          st_d[i] = S_FLY;
          x_d[i]  = spawn_x;
          y_d[i]  = spawn_y;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      lfsr_q <= 8'h01;
      cd_q   <= '0;
      fire_q <= 1'b0;
      for (int i = 0; i < NUM_MISSILE; i++) begin
        st_q[i] <= S_IDLE;
        x_q[i]  <= '0;
        y_q[i]  <= '0;
      end
    end else begin
      lfsr_q <= lfsr_d;
      cd_q   <= cd_d;
      fire_q <= fire_d;
      for (int i = 0; i < NUM_MISSILE; i++) begin
        st_q[i] <= st_d[i];
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_MISSILE; g++) begin : g_out
    assign bus.beam_X[g]      = x_q[g];
    assign bus.beam_Y[g]      = y_q[g];
    assign bus.beam_enable[g] = (st_q[g] == S_FLY);
  end

  assign bus.fire_pulse = fire_q;
endmodule

// File: tb/tb_enemy_missile_pool.sv
// Directed bench for enemy_missile_pool; expected frames come from the hand-stepped LFSR sequence
// 01 02 04 08 11 23 47 8E 1C 38 71 E2 C4 89 12 25 4B 97 2E 5C B8 70 E0 C0 81 03 06 0C 19 32 64 ... E4 C8.
module tb_enemy_missile_pool;
`ifdef ENEMY_MISSILE_AIM_EN
  localparam bit AIM = 1'b1;
`else
  localparam bit AIM = 1'b0;
`endif

  logic frame_clk;
  logic Reset;
  int   frame;
  int   vectors;
  int   miscompares;
  logic stray, stray2;

  enemy_missile_pool_if #(.NUM_ENEMY(24), .NUM_MISSILE(4)) bus ();

  enemy_missile_pool dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (bus)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
    if (!Reset) frame++;
  endtask

  // Advance to frame 'last', flagging any fire_pulse seen on the way.
  task automatic run_quiet(input int last, output logic seen);
    seen = 1'b0;
    while (frame < last) begin
      tick();
      if (bus.fire_pulse !== 1'b0) seen = 1'b1;
    end
  endtask

  task automatic chk_slot(input string tag, input int s, input int ex, input int ey);
    chk({tag, "_x"}, 32'(bus.beam_X[s]), ex);
    chk({tag, "_y"}, 32'(bus.beam_Y[s]), ey);
  endtask

  initial begin
    vectors = 0; miscompares = 0; frame = 0;
    Reset = 1'b1;
    bus.freeze = 1'b0;
    bus.hit_clr = '0;
    bus.present = '0;
    bus.enemy_posX = '0;
    bus.enemy_posY = '0;
`ifdef ENEMY_MISSILE_AIM_EN
    bus.player_X = 10'd120;
`endif
    bus.enemy_posX[5] = 10'd100;
    bus.enemy_posY[5] = 10'd40;
    bus.present[5] = 1'b1;
    tick(); tick();
    chk("rst_enable", 32'(bus.beam_enable), 0);
    chk("rst_fire",   32'(bus.fire_pulse), 0);
    chk_slot("rst_s0", 0, 0, 0);
    Reset = 1'b0; frame = 0;

    // only enemy 5 alive: first lfsr[4:0]==5 occurs at frame 16
    run_quiet(15, stray);
    chk("pre_launch_quiet", 32'(stray), 0);
    tick();
    chk("launch_enable", 32'(bus.beam_enable), 4'b0001);
    chk("launch_fire",   32'(bus.fire_pulse), 1);
    chk_slot("launch_s0", 0, 100, 48);
    bus.present = '0;
    run_quiet(21, stray);
    chk("fly_fire_clear", 32'(bus.fire_pulse), 0);
    chk_slot("fly5_s0", 0, AIM ? 105 : 100, 68);

    // async reset mid-flight
    Reset = 1'b1;
    #1;
    chk("midrst_enable", 32'(bus.beam_enable), 0);
    chk("midrst_fire",   32'(bus.fire_pulse), 0);
    chk_slot("midrst_s0", 0, 0, 0);
    tick(); tick();
    chk("midrst_hold_enable", 32'(bus.beam_enable), 0);
    Reset = 1'b0; frame = 0;
    bus.present[5] = 1'b1;
    run_quiet(15, stray);
    chk("relaunch_quiet", 32'(stray), 0);
    tick();
    chk("relaunch_enable", 32'(bus.beam_enable), 4'b0001);
    chk_slot("relaunch_s0", 0, 100, 48);
    bus.present = '0;
    run_quiet(75, stray);
    chk("last_fly_enable", 32'(bus.beam_enable), 4'b0001);
    chk_slot("last_fly_s0", 0, AIM ? 120 : 100, 284);
    tick();
    chk("retire_enable", 32'(bus.beam_enable), 0);
    chk_slot("retire_s0", 0, 0, 0);

    // all enemies present: launches at frames 1, 11, 22, 31 (shooters 1, 17, 16, 4)
    Reset = 1'b1;
    #1;
    tick();
    for (int i = 0; i < 24; i++) begin
      bus.enemy_posX[i] = 10'(200 + i);
      bus.enemy_posY[i] = 10'(30 + i);
    end
    bus.present = '1;
    Reset = 1'b0; frame = 0;
    tick();
    chk("l0_enable", 32'(bus.beam_enable), 4'b0001);
    chk("l0_fire",   32'(bus.fire_pulse), 1);
    chk_slot("l0_s0", 0, 201, 39);
    run_quiet(10, stray);
    chk("gap1_quiet", 32'(stray), 0);
    tick();
    chk("l1_enable", 32'(bus.beam_enable), 4'b0011);
    chk("l1_fire",   32'(bus.fire_pulse), 1);
    chk_slot("l1_s1", 1, 217, 55);
    run_quiet(21, stray);
    chk("gap2_quiet", 32'(stray), 0);
    tick();
    chk("l2_enable", 32'(bus.beam_enable), 4'b0111);
    chk_slot("l2_s2", 2, 216, 54);
    run_quiet(30, stray);
    chk("gap3_quiet", 32'(stray), 0);
    tick();
    chk("l3_enable", 32'(bus.beam_enable), 4'b1111);
    chk_slot("l3_s3", 3, 204, 42);
    run_quiet(44, stray);
    chk("full_no_fire", 32'(stray), 0);
    chk("full_enable", 32'(bus.beam_enable), 4'b1111);

    // hit on slot1: cleared next frame, reused one frame later
    bus.hit_clr = 4'b0010;
    tick();
    bus.hit_clr = '0;
    chk("hit_enable", 32'(bus.beam_enable), 4'b1101);
    chk("hit_no_same_frame_fire", 32'(bus.fire_pulse), 0);
    chk_slot("hit_s1", 1, 0, 0);
    tick();
    chk("reuse_fire",   32'(bus.fire_pulse), 1);
    chk("reuse_enable", 32'(bus.beam_enable), 4'b1111);
    chk_slot("reuse_s1", 1, 208, 46);

    // freeze frames 47..56, hit on slot2 while frozen
    bus.freeze = 1'b1;
    run_quiet(49, stray);
    bus.hit_clr = 4'b0100;
    tick();
    bus.hit_clr = '0;
    chk("frz_hit_enable", 32'(bus.beam_enable), 4'b1011);
    chk_slot("frz_hit_s2", 2, 0, 0);
    run_quiet(56, stray2);
    chk("frz_no_fire", 32'(stray | stray2), 0);
    chk("frz_enable", 32'(bus.beam_enable), 4'b1011);
    chk_slot("frz_s0", 0, AIM ? 156 : 201, 219);
    chk("frz_s3_y", 32'(bus.beam_Y[3]), 102);
    bus.freeze = 1'b0;
    run_quiet(64, stray);
    chk("cooldown_held_no_fire", 32'(stray), 0);
    chk("unfrz_s0_y", 32'(bus.beam_Y[0]), 251);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
